// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: generic pipeline stage register with valid/ready handshake.
//
// Carries an opaque payload plus a control bundle between two pipeline stages.
// Supports back-pressure, synchronous flush with bubble insertion and an
// optional 2-entry skid buffer that makes in_ready a register output.
// Saturating stall/flush counters are provided for performance debug.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset (highest priority)
//   flush      kill all held entries; an entry accepted this cycle is dropped
//   in_valid   upstream entry valid
//   in_ready   stage can accept an entry this cycle
//   in_data    upstream payload
//   in_ctrl    upstream control bundle
//   out_valid  head entry valid
//   out_ready  downstream consumes the head entry this cycle
//   out_data   head payload (0 when out_valid=0)
//   out_ctrl   head control (CTRL_NOP when out_valid=0)
//   occupancy  number of held entries
//   stall_cnt  cycles with out_valid & ~out_ready, saturating
//   flush_cnt  flush cycles that discarded at least one entry, saturating
module pipe_stage_hs #(
  parameter int unsigned           DATA_W   = 160,
  parameter int unsigned           CTRL_W   = 8,
  parameter logic [CTRL_W-1:0]     CTRL_NOP = '0,
  parameter int unsigned           SKID     = 1,
  parameter int unsigned           CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Head entry M and skid entry S
  logic              mv_q, mv_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic              sv_q, sv_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [1:0]        occ_q, occ_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic accept;
  logic pop;

  // With the skid buffer, in_ready depends only on sv_q, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready = (SKID != 0) ? ~sv_q : (~mv_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign pop      = mv_q & out_ready;

  always_comb begin
    mv_d     = mv_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    sv_d     = sv_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;

    if (SKID != 0) begin
      if (pop && sv_q) begin
        // Skid entry moves to head; accept is impossible since in_ready=0
        mv_d     = 1'b1;
        m_data_d = s_data_q;
        m_ctrl_d = s_ctrl_q;
        sv_d     = 1'b0;
        s_data_d = '0;
        s_ctrl_d = CTRL_NOP;
      end else if (accept && (!mv_q || pop)) begin
        mv_d     = 1'b1;
        m_data_d = in_data;
        m_ctrl_d = in_ctrl;
      end else if (accept) begin
        // Head is stalled: park the new entry in the skid slot
        sv_d     = 1'b1;
        s_data_d = in_data;
        s_ctrl_d = in_ctrl;
      end else if (pop) begin
        mv_d     = 1'b0;
        m_data_d = '0;
        m_ctrl_d = CTRL_NOP;
      end
    end else begin
      if (accept) begin
        mv_d     = 1'b1;
        m_data_d = in_data;
        m_ctrl_d = in_ctrl;
      end else if (pop) begin
        mv_d     = 1'b0;
        m_data_d = '0;
        m_ctrl_d = CTRL_NOP;
      end
      sv_d     = 1'b0;
      s_data_d = '0;
      s_ctrl_d = CTRL_NOP;
    end

    // Flush turns everything into bubbles, including a same-cycle accept
    if (flush) begin
      mv_d     = 1'b0;
      m_data_d = '0;
      m_ctrl_d = CTRL_NOP;
      sv_d     = 1'b0;
      s_data_d = '0;
      s_ctrl_d = CTRL_NOP;
    end

    occ_d = {1'b0, mv_d} + {1'b0, sv_d};

    stall_d = stall_q;
    if (mv_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end

    flush_d = flush_q;
    if (flush && (mv_q || sv_q) && (flush_q != {CNT_W{1'b1}})) begin
      flush_d = flush_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mv_q     <= 1'b0;
      m_data_q <= '0;
      m_ctrl_q <= CTRL_NOP;
      sv_q     <= 1'b0;
      s_data_q <= '0;
      s_ctrl_q <= CTRL_NOP;
      occ_q    <= 2'd0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      mv_q     <= mv_d;
      m_data_q <= m_data_d;
      m_ctrl_q <= m_ctrl_d;
      sv_q     <= sv_d;
      s_data_q <= s_data_d;
      s_ctrl_q <= s_ctrl_d;
      occ_q    <= occ_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  assign out_valid = mv_q;
  assign out_data  = m_data_q;
  assign out_ctrl  = m_ctrl_q;
  assign occupancy = occ_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Self-checking bench for pipe_stage_hs.
// Three instances: A (SKID=1, default widths, non-zero CTRL_NOP),
// B (SKID=0), C (SKID=1, CNT_W=4 for saturation).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge. Scoreboard monitors pop expected entries on each
// out_valid & out_ready handshake.
module tb_pipe_stage_hs;

  localparam logic [7:0] NOP_A = 8'h5A;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [167:0] act, input logic [167:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- Instance A ----------------
  logic         flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [159:0] in_data_a, out_data_a;
  logic [7:0]   in_ctrl_a, out_ctrl_a;
  logic [1:0]   occ_a;
  logic [15:0]  stall_a, flushc_a;

  pipe_stage_hs #(.DATA_W(160), .CTRL_W(8), .CTRL_NOP(NOP_A), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a), .in_ctrl(in_ctrl_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_ctrl(out_ctrl_a), .occupancy(occ_a), .stall_cnt(stall_a), .flush_cnt(flushc_a)
  );

  // ---------------- Instance B ----------------
  logic        flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [15:0] in_data_b, out_data_b;
  logic [7:0]  in_ctrl_b, out_ctrl_b;
  logic [1:0]  occ_b;
  logic [15:0] stall_b, flushc_b;

  pipe_stage_hs #(.DATA_W(16), .CTRL_W(8), .CTRL_NOP(8'h00), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .flush(flush_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_ctrl(in_ctrl_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_ctrl(out_ctrl_b), .occupancy(occ_b), .stall_cnt(stall_b), .flush_cnt(flushc_b)
  );

  // ---------------- Instance C ----------------
  logic       flush_c, in_valid_c, in_ready_c, out_valid_c, out_ready_c;
  logic [7:0] in_data_c, out_data_c;
  logic [3:0] in_ctrl_c, out_ctrl_c;
  logic [1:0] occ_c;
  logic [3:0] stall_c, flushc_c;

  pipe_stage_hs #(.DATA_W(8), .CTRL_W(4), .CTRL_NOP(4'h0), .SKID(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .flush(flush_c),
    .in_valid(in_valid_c), .in_ready(in_ready_c), .in_data(in_data_c), .in_ctrl(in_ctrl_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c), .out_data(out_data_c),
    .out_ctrl(out_ctrl_c), .occupancy(occ_c), .stall_cnt(stall_c), .flush_cnt(flushc_c)
  );

  // ---------------- Scoreboards ----------------
  logic [167:0] q_a[$];  // {ctrl, data}
  logic [23:0]  q_b[$];  // {ctrl, data}

  always @(negedge clk) begin
    logic [167:0] e;
    if (!rst && out_valid_a && out_ready_a) begin
      if (q_a.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL a_unexpected: got data %0h ctrl %0h expected no entry",
                 out_data_a, out_ctrl_a);
      end else begin
        e = q_a.pop_front();
        check("a_out_data", {8'h0, out_data_a}, {8'h0, e[159:0]});
        check("a_out_ctrl", {160'h0, out_ctrl_a}, {160'h0, e[167:160]});
      end
    end
  end

  always @(negedge clk) begin
    logic [23:0] e;
    if (!rst && out_valid_b && out_ready_b) begin
      if (q_b.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL b_unexpected: got data %0h ctrl %0h expected no entry",
                 out_data_b, out_ctrl_b);
      end else begin
        e = q_b.pop_front();
        check("b_out_data", {152'h0, out_data_b}, {152'h0, e[15:0]});
        check("b_out_ctrl", {160'h0, out_ctrl_b}, {160'h0, e[23:16]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [159:0] d, input logic [7:0] c);
    in_valid_a = 1'b1;
    in_data_a  = d;
    in_ctrl_a  = c;
  endtask

  initial begin
    rst = 1'b1;
    flush_a = 0; in_valid_a = 0; in_data_a = '0; in_ctrl_a = '0; out_ready_a = 0;
    flush_b = 0; in_valid_b = 0; in_data_b = '0; in_ctrl_b = '0; out_ready_b = 0;
    flush_c = 0; in_valid_c = 0; in_data_c = '0; in_ctrl_c = '0; out_ready_c = 0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", {167'h0, in_ready_a}, 168'd1);
    check("rst_occ", {166'h0, occ_a}, 168'd0);
    check("rst_out_valid", {167'h0, out_valid_a}, 168'd0);
    check("rst_out_data", {8'h0, out_data_a}, 168'd0);
    check("rst_out_ctrl", {160'h0, out_ctrl_a}, {160'h0, NOP_A});
    check("rst_stall", {152'h0, stall_a}, 168'd0);
    check("rst_flush", {152'h0, flushc_a}, 168'd0);
    step();

    // Stream 1..4 with out_ready=1
    out_ready_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push_a(160'(i), 8'(8'h10 + i));
      q_a.push_back({8'(8'h10 + i), 160'(i)});
      @(negedge clk);
      check("stream_in_ready", {167'h0, in_ready_a}, 168'd1);
      if (i > 1) check("stream_out_valid", {167'h0, out_valid_a}, 168'd1);
      step();
    end
    in_valid_a = 1'b0;
    step();
    @(negedge clk);
    check("stream_stall", {152'h0, stall_a}, 168'd0);
    check("stream_occ", {166'h0, occ_a}, 168'd0);
    step();

    // Back-pressure: A and B pushed while out_ready=0
    out_ready_a = 1'b0;
    push_a(160'hAAAA, 8'h21);
    q_a.push_back({8'h21, 160'hAAAA});
    step();
    push_a(160'hBBBB, 8'h22);
    q_a.push_back({8'h22, 160'hBBBB});
    @(negedge clk);
    check("bp_in_ready_1", {167'h0, in_ready_a}, 168'd1);
    step();
    in_valid_a = 1'b0;
    @(negedge clk);
    check("bp_occ2", {166'h0, occ_a}, 168'd2);
    check("bp_in_ready_0", {167'h0, in_ready_a}, 168'd0);
    check("bp_hold_a", {8'h0, out_data_a}, 168'hAAAA);
    check("bp_stall1", {152'h0, stall_a}, 168'd1);
    step();
    @(negedge clk);
    check("bp_stall2", {152'h0, stall_a}, 168'd2);
    check("bp_hold_a2", {8'h0, out_data_a}, 168'hAAAA);
    step();
    out_ready_a = 1'b1;
    @(negedge clk);
    check("bp_in_ready_pop", {167'h0, in_ready_a}, 168'd0);
    step();
    @(negedge clk);
    check("bp_in_ready_after", {167'h0, in_ready_a}, 168'd1);
    check("bp_stall3", {152'h0, stall_a}, 168'd3);
    step();

    // Flush with occupancy=2 and a concurrent input C
    out_ready_a = 1'b0;
    push_a(160'hDDDD, 8'h23);
    step();
    push_a(160'hEEEE, 8'h24);
    step();
    flush_a = 1'b1;
    push_a(160'hCCCC, 8'h25);
    @(negedge clk);
    check("fl_occ_before", {166'h0, occ_a}, 168'd2);
    step();
    flush_a = 1'b0;
    in_valid_a = 1'b0;
    @(negedge clk);
    check("fl_out_valid", {167'h0, out_valid_a}, 168'd0);
    check("fl_out_ctrl", {160'h0, out_ctrl_a}, {160'h0, NOP_A});
    check("fl_out_data", {8'h0, out_data_a}, 168'd0);
    check("fl_occ", {166'h0, occ_a}, 168'd0);
    check("fl_cnt", {152'h0, flushc_a}, 168'd1);
    check("fl_stall", {152'h0, stall_a}, 168'd5);
    check("fl_in_ready", {167'h0, in_ready_a}, 168'd1);
    step();
    out_ready_a = 1'b1;
    step();
    step();

    // Flush while empty, with an input that must be discarded
    flush_a = 1'b1;
    push_a(160'hFFFF, 8'h26);
    step();
    flush_a = 1'b0;
    in_valid_a = 1'b0;
    @(negedge clk);
    check("fe_cnt", {152'h0, flushc_a}, 168'd1);
    check("fe_out_valid", {167'h0, out_valid_a}, 168'd0);
    check("fe_out_data", {8'h0, out_data_a}, 168'd0);
    check("fe_out_ctrl", {160'h0, out_ctrl_a}, {160'h0, NOP_A});
    check("fe_occ", {166'h0, occ_a}, 168'd0);
    step();
    step();

    // SKID=0: combinational in_ready and pop+accept without a bubble
    out_ready_b = 1'b0;
    in_valid_b = 1'b1; in_data_b = 16'h0101; in_ctrl_b = 8'h31;
    q_b.push_back({8'h31, 16'h0101});
    @(negedge clk);
    check("s0_in_ready_empty", {167'h0, in_ready_b}, 168'd1);
    step();
    in_data_b = 16'h0202; in_ctrl_b = 8'h32;
    q_b.push_back({8'h32, 16'h0202});
    @(negedge clk);
    check("s0_in_ready_full", {167'h0, in_ready_b}, 168'd0);
    check("s0_occ", {166'h0, occ_b}, 168'd1);
    step();
    out_ready_b = 1'b1;
    #1;
    check("s0_in_ready_comb", {167'h0, in_ready_b}, 168'd1);
    step();
    in_valid_b = 1'b0;
    @(negedge clk);
    check("s0_no_bubble_valid", {167'h0, out_valid_b}, 168'd1);
    check("s0_no_bubble_data", {152'h0, out_data_b}, 168'h0202);
    step();
    out_ready_b = 1'b0;
    @(negedge clk);
    check("s0_drained", {167'h0, out_valid_b}, 168'd0);
    step();

    // Saturation with CNT_W=4
    in_valid_c = 1'b1; in_data_c = 8'h33; in_ctrl_c = 4'h3;
    step();
    in_valid_c = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("sat_stall10", {164'h0, stall_c}, 168'd10);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("sat_stall15", {164'h0, stall_c}, 168'd15);
    check("sat_hold_data", {160'h0, out_data_c}, 168'h33);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sat_stays15", {164'h0, stall_c}, 168'd15);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("sat_rst", {164'h0, stall_c}, 168'd0);
    check("end_q_a_empty", 168'(q_a.size()), 168'd0);
    check("end_q_b_empty", 168'(q_b.size()), 168'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
